wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (WE3/A3/WD3) between the in-order W stage and the multi-cycle MCycle unit (mul/div).
- The W stage is never stalled and always has priority.
- MCycle results are queued in a small FIFO and drained into idle port cycles.
- Raises a stall request to the hazard unit when a queued result has waited too long.

Parameters:
- DEPTH, 2, MCycle result FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go undrained before StallReq asserts

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-high reset
- RegWriteW  in  1  W-stage write enable
- rdW  in  5  W-stage destination register
- ResultW  in  32  W-stage writeback data (already muxed ReadData/ComputeResult)
- MC_Valid  in  1  MCycle result valid
- MC_Rd  in  5  MCycle destination register
- MC_Result  in  32  MCycle result data
- MC_Ready  out  1  FIFO can accept (count != DEPTH)
- WE3  out  1  register-file write enable
- A3  out  5  register-file write address
- WD3  out  32  register-file write data
- StallReq  out  1  request hazard unit to insert a W-stage bubble
- Busy  out  1  FIFO non-empty (count != 0)

Behaviour:
- Reset (asynchronous, immediate): FIFO count = 0, pointers = 0, all kill bits = 0, starve counter = 0, StallReq = 0.
  - While RESET is high: MC_Ready = 1, Busy = 0, WE3 = 0, A3 = 0, WD3 = 0.
  - Reset mid-operation discards all queued results without writing them.
- Pipeline write (PW) = RegWriteW && rdW != 0.
  - rdW == 0 never consumes the port.
- Port select (combinational, same cycle):
  - If PW: WE3 = 1, A3 = rdW, WD3 = ResultW.
  - Else if Busy: pop the head. WE3 = !kill[head], A3 = head.rd, WD3 = head.data.
  - Else: WE3 = 0, A3 = 0, WD3 = 0.
- Push: on a clock edge with MC_Valid && MC_Ready, write {rd, data, kill = 0} at the tail.
  - MC_Rd == 0 is pushed with kill = 1 (drained with no write).
  - Push-to-write latency is at least 1 cycle; no FIFO bypass.
- MC_Ready depends only on the registered count, never on the same-cycle pop.
  - A push and a pop in the same cycle leave count unchanged.
  - When full, MC_Ready = 0 even if a pop occurs that cycle.
- WAW ordering: when PW and rdW matches any valid, non-killed FIFO entry, set that entry's kill bit at the edge.
  - The newer pipeline value must never be overwritten by the older MCycle result.
  - A result pushed in the same cycle as a matching PW is NOT killed; it is younger than the W write.
- Starve counter:
  - Increments each cycle Busy && PW (head blocked).
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- StallReq is registered.
  - Sets on the edge where the counter reaches STARVE_LIMIT.
  - Clears on the edge after the first pop.
  - The hazard unit guarantees a bubble (RegWriteW = 0) reaches W within 3 cycles of StallReq.
- Pointer arithmetic is modulo DEPTH (wrap-around); count is $clog2(DEPTH)+1 bits.
- No X on outputs: when WE3 = 0 in idle cycles, A3 and WD3 are 0.

Decomposition:
- Shared package mach_v_pkg holds XLEN = 32, REG_ADDR_W = 5, and a wb_entry_t struct {kill, rd, data}.
- Sub-module wb_fifo holds storage, pointers, count, per-entry kill bits, and the rd-match kill port.
  - Parameterised by DEPTH.
  - Exposes full/empty/head.
- The top level holds port selection, the starve counter, and StallReq.

Test Plan:
- Reset: assert RESET mid-cycle with 2 entries queued → WE3 = 0, Busy = 0, MC_Ready = 1 immediately; no queued write ever appears after release.
- Idle drain: RegWriteW = 0; MC pushes rd = 5, data = 0xDEADBEEF at edge N → WE3 = 1, A3 = 5, WD3 = 0xDEADBEEF in cycle N+1; Busy = 0 after edge N+1.
- Collision: push rd = 7 / 0x11 while RegWriteW = 1, rdW = 3 on three consecutive cycles → three W writes to x3. The x7 write occurs in the first cycle RegWriteW = 0.
- Full/backpressure: hold PW high; push 2 results → MC_Ready = 0. A third MC_Valid is held, not accepted. Count stays 2; after one free cycle, count drops to 1 and MC_Ready = 1.
- WAW kill: queue rd = 9 / 0xAAAA, then PW rdW = 9 / 0xBBBB → at drain WE3 = 0 for that entry; x9 final value = 0xBBBB.
- Starvation: Busy with PW high for 4 cycles → StallReq = 1 on the 4th edge. Drive RegWriteW = 0 one cycle → entry pops and StallReq = 0 next edge.

Source files
------------

// File: rtl/mach_v_pkg.sv
// mach_v_pkg: shared datapath widths and the writeback queue entry type.
package mach_v_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    typedef struct packed {
        logic kill;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: MCycle result queue with per-entry kill bits for WAW suppression.
module wb_fifo
    import mach_v_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] pushRd,
    input  logic [XLEN-1:0]       pushData,
    input  logic                  pop,
    input  logic                  killEn,
    input  logic [REG_ADDR_W-1:0] killRd,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t             head
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count;
    logic [DEPTH-1:0] live;
    logic doPush, doPop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign doPush = push && !full;
    assign doPop = pop && !empty;
    assign head = mem[rdPtr];
    // An entry is live when its distance from the head is below the count.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = {1'b0, AW'(i) - rdPtr} < count;
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (killEn && live[i] && mem[i].rd == killRd) mem[i].kill <= 1'b1;
            // The tail slot is never live here, so a same-cycle push stays unkilled.
            if (doPush) mem[wrPtr] <= '{kill: pushRd == '0, rd: pushRd, data: pushData};
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop) rdPtr <= rdPtr + AW'(1);
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the W stage
// and queued MCycle results, requesting a bubble when the queue starves.
module wb_port_arbiter
    import mach_v_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic [XLEN-1:0]       ResultW,
    input  logic                  MC_Valid,
    input  logic [REG_ADDR_W-1:0] MC_Rd,
    input  logic [XLEN-1:0]       MC_Result,
    output logic                  MC_Ready,
    output logic                  WE3,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [XLEN-1:0]       WD3,
    output logic                  StallReq,
    output logic                  Busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic pw, pop, full, empty, stallNext;
    wb_entry_t head;
    logic [SW-1:0] starve, starveNext;
    wb_fifo #(.DEPTH(DEPTH)) fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (MC_Valid && MC_Ready),
        .pushRd  (MC_Rd),
        .pushData(MC_Result),
        .pop     (pop),
        .killEn  (pw),
        .killRd  (rdW),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );
    // Reset is folded in so the port reads idle the instant RESET rises.
    assign pw = RegWriteW && rdW != '0 && !RESET;
    assign Busy = !empty;
    assign MC_Ready = !full;
    assign pop = Busy && !pw && !RESET;
    assign WE3 = pw || (pop && !head.kill);
    assign A3 = pw ? rdW : pop ? head.rd : '0;
    assign WD3 = pw ? ResultW : pop ? head.data : '0;
    always_comb begin
        starveNext = (empty || pop) ? '0 :
                     (pw && starve != SW'(STARVE_LIMIT)) ? starve + SW'(1) : starve;
        stallNext = (empty || pop) ? 1'b0 :
                    (starveNext == SW'(STARVE_LIMIT)) ? 1'b1 : StallReq;
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            starve <= '0;
            StallReq <= 1'b0;
        end else begin
            starve <= starveNext;
            StallReq <= stallNext;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of port sharing, backpressure, WAW kill,
// starvation stall and asynchronous reset.
module tb_wb_port_arbiter;
    logic CLK = 1'b0;
    logic RESET, RegWriteW, MC_Valid, MC_Ready, WE3, StallReq, Busy;
    logic [4:0] rdW, MC_Rd, A3;
    logic [31:0] ResultW, MC_Result, WD3;
    logic [31:0] rf [32];
    int total = 0;
    int bad = 0;
    int ghost = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RESET(RESET), .RegWriteW(RegWriteW), .rdW(rdW), .ResultW(ResultW),
        .MC_Valid(MC_Valid), .MC_Rd(MC_Rd), .MC_Result(MC_Result), .MC_Ready(MC_Ready),
        .WE3(WE3), .A3(A3), .WD3(WD3), .StallReq(StallReq), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // Register-file sink: records what the port actually commits.
    always @(posedge CLK) begin
        if (WE3 === 1'b1) begin
            rf[A3] <= WD3;
            if (A3 == 5'd20 || A3 == 5'd21) ghost <= ghost + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        #1;
        check({tag, ".WE3"}, 32'(WE3), 32'(we));
        check({tag, ".A3"}, 32'(A3), 32'(a));
        check({tag, ".WD3"}, WD3, d);
    endtask

    task automatic wdrive(input logic we, input logic [4:0] r, input logic [31:0] d);
        RegWriteW = we;
        rdW = r;
        ResultW = d;
    endtask

    task automatic mdrive(input logic v, input logic [4:0] r, input logic [31:0] d);
        MC_Valid = v;
        MC_Rd = r;
        MC_Result = d;
    endtask

    initial begin
        RESET = 1'b1;
        wdrive(1'b0, 5'd0, 32'h0);
        mdrive(1'b0, 5'd0, 32'h0);
        step();
        port("reset", 1'b0, 5'd0, 32'h0);
        check("reset.MC_Ready", 32'(MC_Ready), 32'd1);
        check("reset.Busy", 32'(Busy), 32'd0);
        check("reset.StallReq", 32'(StallReq), 32'd0);
        RESET = 1'b0;

        // Idle drain: one cycle push-to-write, no bypass
        mdrive(1'b1, 5'd5, 32'hDEADBEEF);
        port("drain.pre", 1'b0, 5'd0, 32'h0);
        step();
        mdrive(1'b0, 5'd0, 32'h0);
        port("drain.N1", 1'b1, 5'd5, 32'hDEADBEEF);
        check("drain.busy", 32'(Busy), 32'd1);
        step();
        check("drain.empty", 32'(Busy), 32'd0);
        port("drain.idle", 1'b0, 5'd0, 32'h0);

        // Collision: W keeps the port for three cycles
        mdrive(1'b1, 5'd7, 32'h11);
        wdrive(1'b1, 5'd3, 32'h33);
        port("coll.c1", 1'b1, 5'd3, 32'h33);
        step();
        mdrive(1'b0, 5'd0, 32'h0);
        port("coll.c2", 1'b1, 5'd3, 32'h33);
        step();
        port("coll.c3", 1'b1, 5'd3, 32'h33);
        step();
        wdrive(1'b0, 5'd0, 32'h0);
        port("coll.drain", 1'b1, 5'd7, 32'h11);
        step();
        check("coll.empty", 32'(Busy), 32'd0);
        check("coll.stall", 32'(StallReq), 32'd0);
        check("coll.rf7", rf[7], 32'h11);

        // Full / backpressure
        wdrive(1'b1, 5'd3, 32'h44);
        mdrive(1'b1, 5'd10, 32'hA0);
        step();
        check("full.ready1", 32'(MC_Ready), 32'd1);
        mdrive(1'b1, 5'd11, 32'hB0);
        step();
        check("full.ready2", 32'(MC_Ready), 32'd0);
        mdrive(1'b1, 5'd12, 32'hC0);
        step();
        check("full.held", 32'(MC_Ready), 32'd0);
        wdrive(1'b0, 5'd0, 32'h0);
        port("full.popA", 1'b1, 5'd10, 32'hA0);
        check("full.readyPop", 32'(MC_Ready), 32'd0);
        step();
        mdrive(1'b0, 5'd0, 32'h0);
        check("full.ready3", 32'(MC_Ready), 32'd1);
        check("full.busy", 32'(Busy), 32'd1);
        port("full.popB", 1'b1, 5'd11, 32'hB0);
        step();
        check("full.empty", 32'(Busy), 32'd0);
        port("full.noC", 1'b0, 5'd0, 32'h0);

        // WAW kill: older MCycle result must not clobber x9
        mdrive(1'b1, 5'd9, 32'hAAAA);
        step();
        mdrive(1'b0, 5'd0, 32'h0);
        wdrive(1'b1, 5'd9, 32'hBBBB);
        port("waw.w", 1'b1, 5'd9, 32'hBBBB);
        step();
        wdrive(1'b0, 5'd0, 32'h0);
        port("waw.killed", 1'b0, 5'd9, 32'hAAAA);
        check("waw.busy", 32'(Busy), 32'd1);
        step();
        check("waw.empty", 32'(Busy), 32'd0);
        check("waw.rf9", rf[9], 32'hBBBB);

        // Same-cycle push with matching W write is younger, not killed
        mdrive(1'b1, 5'd9, 32'hCCCC);
        wdrive(1'b1, 5'd9, 32'hDDDD);
        step();
        mdrive(1'b0, 5'd0, 32'h0);
        wdrive(1'b0, 5'd0, 32'h0);
        port("young.drain", 1'b1, 5'd9, 32'hCCCC);
        step();
        check("young.rf9", rf[9], 32'hCCCC);

        // rd=0 result drains silently; rdW=0 never takes the port
        mdrive(1'b1, 5'd0, 32'h55);
        step();
        mdrive(1'b1, 5'd4, 32'h44);
        port("x0.drain", 1'b0, 5'd0, 32'h55);
        step();
        mdrive(1'b0, 5'd0, 32'h0);
        wdrive(1'b1, 5'd0, 32'hFF);
        port("x0.rdW0", 1'b1, 5'd4, 32'h44);
        step();
        wdrive(1'b0, 5'd0, 32'h0);
        check("x0.empty", 32'(Busy), 32'd0);

        // Starvation stall
        mdrive(1'b1, 5'd6, 32'h66);
        step();
        mdrive(1'b0, 5'd0, 32'h0);
        wdrive(1'b1, 5'd3, 32'h77);
        step();
        step();
        step();
        check("starve.e3", 32'(StallReq), 32'd0);
        step();
        check("starve.e4", 32'(StallReq), 32'd1);
        wdrive(1'b0, 5'd0, 32'h0);
        port("starve.pop", 1'b1, 5'd6, 32'h66);
        step();
        check("starve.clear", 32'(StallReq), 32'd0);
        check("starve.empty", 32'(Busy), 32'd0);

        // Asynchronous reset discards queued results
        wdrive(1'b1, 5'd3, 32'h88);
        mdrive(1'b1, 5'd20, 32'h2020);
        step();
        mdrive(1'b1, 5'd21, 32'h2121);
        step();
        mdrive(1'b0, 5'd0, 32'h0);
        check("rst.full", 32'(MC_Ready), 32'd0);
        #1 RESET = 1'b1;
        port("rst.mid", 1'b0, 5'd0, 32'h0);
        check("rst.busy", 32'(Busy), 32'd0);
        check("rst.ready", 32'(MC_Ready), 32'd1);
        step();
        RESET = 1'b0;
        wdrive(1'b0, 5'd0, 32'h0);
        step();
        step();
        step();
        port("rst.after", 1'b0, 5'd0, 32'h0);
        check("rst.ghost", 32'(ghost), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
